// File: rtl/aq_reduce_pkg.sv
// Shared types and constants for the aq_reduce frame controllers.
package aq_reduce_pkg;
  localparam int GEO_W             = 16;
  localparam int CNT_W             = 32;
  localparam int DRAIN_TIMEOUT_DEF = 64;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CHECK  = 3'd1,
    ST_SYNC   = 3'd2,
    ST_STREAM = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_FIN    = 3'd5
  } state_e;
endpackage

// File: rtl/aq_reduce_geo_chk.sv
// Geometry validity check and registered input/output pixel totals.
module aq_reduce_geo_chk
  import aq_reduce_pkg::*;
(
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic [GEO_W-1:0] org_x,
  input  logic [GEO_W-1:0] org_y,
  input  logic [GEO_W-1:0] cnv_x,
  input  logic [GEO_W-1:0] cnv_y,
  output logic             geo_ok,
  output logic [CNT_W-1:0] in_total,
  output logic [CNT_W-1:0] out_total
);

  logic [CNT_W-1:0] in_total_r;
  logic [CNT_W-1:0] out_total_r;

  // Downscale only: every dimension nonzero and target no larger than source.
  assign geo_ok = (org_x != {GEO_W{1'b0}}) && (org_y != {GEO_W{1'b0}}) &&
                  (cnv_x != {GEO_W{1'b0}}) && (cnv_y != {GEO_W{1'b0}}) &&
                  (cnv_x <= org_x) && (cnv_y <= org_y);

  // Frame pixel totals captured while the controller sits in CHECK.
  always_ff @(posedge CLK) begin
    if (RST) begin
      in_total_r  <= {CNT_W{1'b0}};
      out_total_r <= {CNT_W{1'b0}};
    end else if (load) begin
      in_total_r  <= CNT_W'(org_x) * CNT_W'(org_y);
      out_total_r <= CNT_W'(cnv_x) * CNT_W'(cnv_y);
    end else begin
      in_total_r  <= in_total_r;
      out_total_r <= out_total_r;
    end
  end

  assign in_total  = in_total_r;
  assign out_total = out_total_r;

endmodule

// File: rtl/aq_reduce_ctrl.sv
// Frame scheduler for the aq_reduce core: validates geometry, streams one
// frame of pixels, and tracks output completion, count and drain timeout.
module aq_reduce_ctrl
  import aq_reduce_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int DRAIN_TIMEOUT = DRAIN_TIMEOUT_DEF,
  parameter int FCNT_W        = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [GEO_W-1:0]  CFG_ORG_X,
  input  logic [GEO_W-1:0]  CFG_ORG_Y,
  input  logic [GEO_W-1:0]  CFG_CNV_X,
  input  logic [GEO_W-1:0]  CFG_CNV_Y,
  input  logic              START,
  input  logic              ABORT,
  input  logic              S_VALID,
  output logic              S_READY,
  input  logic [DATA_W-1:0] S_DATA,
  output logic [GEO_W-1:0]  ORG_X,
  output logic [GEO_W-1:0]  ORG_Y,
  output logic [GEO_W-1:0]  CNV_X,
  output logic [GEO_W-1:0]  CNV_Y,
  output logic              DIN_WE,
  output logic              DIN_FSYNC,
  output logic [DATA_W-1:0] DIN,
  input  logic              DOUT_OE,
  input  logic              DOUT_LAST,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR_CFG,
  output logic              ERR_CNT,
  output logic              ERR_TMO,
  output logic [FCNT_W-1:0] FRAME_CNT
);

  localparam int TMO_W = $clog2(DRAIN_TIMEOUT + 1);

  state_e             state_r, state_nxt_s;
  logic [GEO_W-1:0]   org_x_r, org_y_r, cnv_x_r, cnv_y_r;
  logic [CNT_W-1:0]   in_cnt_r, out_cnt_r, in_total_s, out_total_s;
  logic [TMO_W-1:0]   tmo_cnt_r;
  logic [7:0]         anom_cnt_r;
  logic [FCNT_W-1:0]  frame_cnt_r;
  logic [DATA_W-1:0]  din_r;
  logic               s_ready_r, din_we_r, din_fsync_r, busy_r, done_r;
  logic               err_cfg_r, err_cnt_r, err_tmo_r;
  logic               geo_ok_s, accept_s, last_in_s, tmo_hit_s, cnt_err_s;

  aq_reduce_geo_chk u_geo_chk (
    .CLK       (CLK),
    .RST       (RST),
    .load      (state_r == ST_CHECK),
    .org_x     (org_x_r),
    .org_y     (org_y_r),
    .cnv_x     (cnv_x_r),
    .cnv_y     (cnv_y_r),
    .geo_ok    (geo_ok_s),
    .in_total  (in_total_s),
    .out_total (out_total_s)
  );

  // s_ready_r is only ever high in STREAM, so it doubles as the state qualifier.
  assign accept_s  = s_ready_r & S_VALID;
  assign last_in_s = (in_cnt_r + CNT_W'(1)) == in_total_s;
  assign tmo_hit_s = tmo_cnt_r == TMO_W'(DRAIN_TIMEOUT - 1);
  assign cnt_err_s = out_cnt_r != out_total_s;

  // Next-state selection; ABORT overrides everything outside IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (START && !ABORT) state_nxt_s = ST_CHECK;
        else                 state_nxt_s = ST_IDLE;
      end
      ST_CHECK: begin
        if (ABORT)         state_nxt_s = ST_IDLE;
        else if (geo_ok_s) state_nxt_s = ST_SYNC;
        else               state_nxt_s = ST_IDLE;
      end
      ST_SYNC: begin
        if (ABORT) state_nxt_s = ST_IDLE;
        else       state_nxt_s = ST_STREAM;
      end
      ST_STREAM: begin
        if (ABORT)                      state_nxt_s = ST_IDLE;
        else if (accept_s && last_in_s) state_nxt_s = ST_DRAIN;
        else                            state_nxt_s = ST_STREAM;
      end
      ST_DRAIN: begin
        if (ABORT)                       state_nxt_s = ST_IDLE;
        else if (DOUT_LAST || tmo_hit_s) state_nxt_s = ST_FIN;
        else                             state_nxt_s = ST_DRAIN;
      end
      ST_FIN:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, datapath, counters and status registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= ST_IDLE;
      org_x_r     <= {GEO_W{1'b0}};
      org_y_r     <= {GEO_W{1'b0}};
      cnv_x_r     <= {GEO_W{1'b0}};
      cnv_y_r     <= {GEO_W{1'b0}};
      in_cnt_r    <= {CNT_W{1'b0}};
      out_cnt_r   <= {CNT_W{1'b0}};
      tmo_cnt_r   <= {TMO_W{1'b0}};
      anom_cnt_r  <= 8'd0;
      frame_cnt_r <= {FCNT_W{1'b0}};
      din_r       <= {DATA_W{1'b0}};
      s_ready_r   <= 1'b0;
      din_we_r    <= 1'b0;
      din_fsync_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_cfg_r   <= 1'b0;
      err_cnt_r   <= 1'b0;
      err_tmo_r   <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      s_ready_r   <= state_nxt_s == ST_STREAM;
      din_fsync_r <= state_nxt_s == ST_SYNC;
      busy_r      <= state_nxt_s != ST_IDLE;
      din_we_r    <= accept_s && !ABORT;
      done_r      <= 1'b0;
      if (accept_s) din_r <= S_DATA;
      case (state_r)
        ST_IDLE: begin
          if (START && !ABORT) begin
            org_x_r   <= CFG_ORG_X;
            org_y_r   <= CFG_ORG_Y;
            cnv_x_r   <= CFG_CNV_X;
            cnv_y_r   <= CFG_CNV_Y;
            in_cnt_r  <= {CNT_W{1'b0}};
            out_cnt_r <= {CNT_W{1'b0}};
            err_cfg_r <= 1'b0;
            err_cnt_r <= 1'b0;
            err_tmo_r <= 1'b0;
          end
        end
        ST_CHECK: begin
          if (!ABORT && !geo_ok_s) begin
            err_cfg_r <= 1'b1;
            done_r    <= 1'b1;
          end
        end
        ST_STREAM: begin
          if (accept_s)  in_cnt_r   <= in_cnt_r + CNT_W'(1);
          if (DOUT_OE)   out_cnt_r  <= out_cnt_r + CNT_W'(1);
          // An early end-of-frame does not complete the frame; it is only tallied.
          if (DOUT_LAST) anom_cnt_r <= anom_cnt_r + 8'd1;
          if (state_nxt_s == ST_DRAIN) tmo_cnt_r <= {TMO_W{1'b0}};
        end
        ST_DRAIN: begin
          tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
          if (DOUT_OE) out_cnt_r <= out_cnt_r + CNT_W'(1);
          if (!ABORT && !DOUT_LAST && tmo_hit_s) err_tmo_r <= 1'b1;
        end
        ST_FIN: begin
          if (!ABORT) begin
            err_cnt_r <= cnt_err_s;
            done_r    <= 1'b1;
            if (!(err_cfg_r || err_tmo_r || cnt_err_s))
              frame_cnt_r <= frame_cnt_r + FCNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign S_READY   = s_ready_r;
  assign ORG_X     = org_x_r;
  assign ORG_Y     = org_y_r;
  assign CNV_X     = cnv_x_r;
  assign CNV_Y     = cnv_y_r;
  assign DIN_WE    = din_we_r;
  assign DIN_FSYNC = din_fsync_r;
  assign DIN       = din_r;
  assign BUSY      = busy_r;
  assign DONE      = done_r;
  assign ERR_CFG   = err_cfg_r;
  assign ERR_CNT   = err_cnt_r;
  assign ERR_TMO   = err_tmo_r;
  assign FRAME_CNT = frame_cnt_r;

endmodule

// File: doc/aq_reduce_ctrl.md
Name: aq_reduce_ctrl

Overview:
- Frame scheduler sitting in front of the aq_reduce downscaler.
- Accepts a software start command and validates the ORG/CNV geometry. It then latches that geometry and holds it stable to the core for the whole frame.
- Issues DIN_FSYNC, gates a ready/valid pixel source into DIN_WE/DIN, and tracks output completion via DOUT_LAST.
- Reports BUSY/DONE/error status, one frame in flight at a time.

Parameters:
- DATA_W, 32, pixel width (ARGB8888) on S_DATA/DIN.
- DRAIN_TIMEOUT, 64, max cycles from last input pixel to DOUT_LAST before error (core latency is about 23).
- FCNT_W, 16, width of completed-frame counter.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous reset, active-high.
- CFG_ORG_X / CFG_ORG_Y  in  16 each  source geometry, sampled on START.
- CFG_CNV_X / CFG_CNV_Y  in  16 each  target geometry, sampled on START.
- START  in  1  one-cycle pulse: begin a frame; ignored unless state is IDLE.
- ABORT  in  1  level/pulse: kill the frame, return to IDLE.
- S_VALID  in  1  upstream pixel valid.
- S_READY  out  1  upstream pixel ready.
- S_DATA  in  DATA_W  upstream pixel.
- ORG_X / ORG_Y / CNV_X / CNV_Y  out  16 each  latched geometry to the core.
- DIN_WE  out  1  pixel write to the core.
- DIN_FSYNC  out  1  frame sync to the core.
- DIN  out  DATA_W  pixel to the core.
- DOUT_OE  in  1  core output strobe.
- DOUT_LAST  in  1  core end-of-frame.
- BUSY  out  1  state is not IDLE.
- DONE  out  1  one-cycle pulse: frame completed, error flags valid.
- ERR_CFG  out  1  sticky until next START: geometry rejected.
- ERR_CNT  out  1  sticky until next START: output count != CNV_X*CNV_Y.
- ERR_TMO  out  1  sticky until next START: drain timeout.
- FRAME_CNT  out  FCNT_W  completed frames; wraps.

Behaviour:
- Reset (RST=1 at a CLK edge) clears all registers:
  - state IDLE; every output 0; geometry registers 0; counters 0.
- All core-side outputs are registered. DIN/DIN_WE are driven from a register, not combinationally from S_*.
- FSM states: IDLE, CHECK, SYNC, STREAM, DRAIN, FIN.
- IDLE:
  - S_READY=0.
  - On START: latch the four CFG_* values, clear the ERR_* flags, go to CHECK.
- CHECK (1 cycle):
  - Valid geometry: ORG_X, ORG_Y, CNV_X, CNV_Y all nonzero, CNV_X<=ORG_X and CNV_Y<=ORG_Y.
  - Invalid: set ERR_CFG, pulse DONE, return to IDLE. FRAME_CNT unchanged, no FSYNC.
  - Valid: compute in_total = ORG_X*ORG_Y and out_total = CNV_X*CNV_Y (32-bit unsigned, registered), go to SYNC.
- SYNC:
  - Assert DIN_FSYNC for exactly 1 cycle, with DIN_WE=0.
  - Next state STREAM. The first DIN_WE occurs at least 1 cycle after FSYNC.
- STREAM:
  - S_READY=1.
  - Each S_VALID&S_READY cycle: DIN<=S_DATA and DIN_WE<=1 on the next cycle, and in_cnt increments.
  - When in_cnt reaches in_total (last accepted pixel): S_READY drops the following cycle, go to DRAIN, and the timeout counter loads 0.
  - S_VALID gaps are legal: DIN_WE=0 on those cycles.
- Output counting:
  - out_cnt increments on DOUT_OE in STREAM and DRAIN (outputs may start before input ends).
  - A DOUT_OE coincident with DOUT_LAST counts.
- DRAIN:
  - Timeout counter increments every cycle.
  - On DOUT_LAST: go to FIN.
  - If the counter reaches DRAIN_TIMEOUT first: set ERR_TMO, go to FIN.
- FIN (1 cycle):
  - ERR_CNT = (out_cnt != out_total).
  - Pulse DONE. FRAME_CNT+1 only if no error.
  - Go to IDLE.
- DOUT_LAST seen in STREAM (premature): ignored for completion, counted as an anomaly. ERR_CNT then arises naturally if the count is short.
- ABORT:
  - Any state except IDLE: next state IDLE, S_READY=0, DIN_WE=0, no DONE, no FRAME_CNT change. Geometry outputs keep their last value.
  - ABORT and START in the same cycle in IDLE: ABORT wins, START is ignored.
- START while BUSY: ignored, with no side effects.
- ORG_*/CNV_* outputs change only in the IDLE->CHECK transition.

Decomposition:
- Shared package aq_reduce_pkg holds:
  - FSM state enum (3-bit).
  - Geometry width constant GEO_W=16.
  - Pixel-count width CNT_W=32.
  - Default DRAIN_TIMEOUT.
- One natural sub-module: aq_reduce_geo_chk.
  - Combinational validity check plus registered in_total/out_total multiply.
  - Reusable by a future enlarge controller.

Test Plan:
- Nominal frame:
  - Stimulus: ORG=4x4, CNV=2x2, START, 16 contiguous pixels; core model emits 4 DOUT_OE, DOUT_LAST on the 4th.
  - Required: one FSYNC before the first DIN_WE; DIN_WE count=16; DONE pulse; no errors; FRAME_CNT=1.
- Bubbled input:
  - Stimulus: same geometry, S_VALID toggling 1/0.
  - Required: DIN_WE mirrors accepted beats one cycle later; S_READY=0 after the 16th accept; DONE with no errors.
- Bad config:
  - Stimulus: CNV_X=5 > ORG_X=4, then separately ORG_Y=0.
  - Required: ERR_CFG=1; DONE within 2 cycles of START; no FSYNC; FRAME_CNT unchanged.
- Drain timeout:
  - Stimulus: valid frame, core model never asserts DOUT_LAST.
  - Required: ERR_TMO set DRAIN_TIMEOUT cycles after entering DRAIN; DONE; FRAME_CNT unchanged; BUSY=0 afterward.
- Count mismatch:
  - Stimulus: CNV=2x2, model emits 3 DOUT_OE then DOUT_LAST.
  - Required: ERR_CNT=1 and DONE.
  - Follow-up: a second START clears ERR_CNT.
- Abort and reset mid-stream:
  - Stimulus: ABORT after 7 pixels, then a new frame.
  - Required: immediate IDLE, S_READY=0, no DONE; the next frame completes cleanly.
  - Stimulus: RST mid-DRAIN.
  - Required: all outputs 0 on the next cycle.
